// File: rtl/cpu_regfile_sb_if.sv
// Bus bundle between the decoder/memory side and the register file:
// two read ports, the ALU write-back port, the load issue/completion port
// and the scoreboard status outputs.
interface cpu_regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3,
    parameter int LED_W  = 8
);
    logic [IDX_W-1:0]  rd_l_idx;
    logic [DATA_W-1:0] rd_l_data;
    logic [IDX_W-1:0]  rd_r_idx;
    logic [DATA_W-1:0] rd_r_data;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              ld_issue;
    logic [IDX_W-1:0]  ld_idx;
    logic              ld_done;
    logic [DATA_W-1:0] ld_data;
    logic              ld_busy;
    logic              ld_full;
    logic              hazard;
    logic [LED_W-1:0]  reg_leds;

    modport master (
        output rd_l_idx, rd_r_idx, wr_en, wr_idx, wr_data,
               ld_issue, ld_idx, ld_done, ld_data,
        input  rd_l_data, rd_r_data, ld_busy, ld_full, hazard, reg_leds
    );

    modport slave (
        input  rd_l_idx, rd_r_idx, wr_en, wr_idx, wr_data,
               ld_issue, ld_idx, ld_done, ld_data,
        output rd_l_data, rd_r_data, ld_busy, ld_full, hazard, reg_leds
    );
endinterface

// File: rtl/cpu_regfile_sb.sv
// General-purpose register file with two bypassed combinational read ports,
// an ALU write-back port and an in-order load scoreboard. Loads are queued
// by destination index when issued and retired oldest-first when the memory
// bus signals completion; the decoder stalls on hazard / ld_full.
module cpu_regfile_sb #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int IDX_W     = 3,
    parameter int MAX_LOADS = 2,
    parameter int LED_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    cpu_regfile_sb_if.slave   bus
);

    localparam int PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
    localparam int CNT_W = $clog2(MAX_LOADS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LOADS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_LOADS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]  fifo [MAX_LOADS];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              ld_busy_q;
    logic              ld_full_q;

    logic [IDX_W-1:0]  head_idx;
    logic              pop;
    logic              push;
    logic              alu_we;
    logic [DATA_W-1:0] rd_l;
    logic [DATA_W-1:0] rd_r;
    logic              hazard_c;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_idx = fifo[head];

    // Decide which writes and FIFO moves happen this cycle; reset suppresses all of them.
    always_comb begin
        pop    = !rst && bus.ld_done && (count != '0);
        push   = !rst && bus.ld_issue && idx_ok(bus.ld_idx) &&
                 ((count != FULL_CNT) || pop);
        alu_we = !rst && bus.wr_en && idx_ok(bus.wr_idx) &&
                 !(pop && (head_idx == bus.wr_idx));
    end

    // Occupancy after this edge: a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Left read port: load data beats ALU data beats storage; no bypass during reset.
    always_comb begin
        rd_l = '0;
        if (idx_ok(bus.rd_l_idx)) begin
            if (pop && (head_idx == bus.rd_l_idx)) begin
                rd_l = bus.ld_data;
            end else if (!rst && bus.wr_en && (bus.wr_idx == bus.rd_l_idx)) begin
                rd_l = bus.wr_data;
            end else begin
                rd_l = regs[bus.rd_l_idx];
            end
        end
    end

    // Right read port: same bypass priority as the left port.
    always_comb begin
        rd_r = '0;
        if (idx_ok(bus.rd_r_idx)) begin
            if (pop && (head_idx == bus.rd_r_idx)) begin
                rd_r = bus.ld_data;
            end else if (!rst && bus.wr_en && (bus.wr_idx == bus.rd_r_idx)) begin
                rd_r = bus.wr_data;
            end else begin
                rd_r = regs[bus.rd_r_idx];
            end
        end
    end

    // Flag any pending load (including the one retiring now) whose destination is being touched.
    always_comb begin : hazard_scan
        int off;
        hazard_c = 1'b0;
        off      = 0;
        for (int i = 0; i < MAX_LOADS; i++) begin
            off = (i >= int'(head)) ? (i - int'(head)) : (i + MAX_LOADS - int'(head));
            if (off < int'(count)) begin
                if ((fifo[i] == bus.rd_l_idx) || (fifo[i] == bus.rd_r_idx) ||
                    (bus.wr_en && (fifo[i] == bus.wr_idx))) begin
                    hazard_c = 1'b1;
                end
            end
        end
    end

    // Scoreboard FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ld_busy_q <= 1'b0;
            ld_full_q <= 1'b0;
        end else begin
            if (push) begin
                fifo[tail] <= bus.ld_idx;
                tail       <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count     <= count_next;
            ld_busy_q <= (count_next != '0);
            ld_full_q <= (count_next == FULL_CNT);
        end
    end

    // Register storage: ALU write-back and load completion (load wins on a shared index).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (alu_we) begin
                regs[bus.wr_idx] <= bus.wr_data;
            end
            if (pop) begin
                regs[head_idx] <= bus.ld_data;
            end
        end
    end

    assign bus.rd_l_data = rd_l;
    assign bus.rd_r_data = rd_r;
    assign bus.ld_busy   = ld_busy_q;
    assign bus.ld_full   = ld_full_q;
    assign bus.hazard    = hazard_c;
    assign bus.reg_leds  = regs[0][LED_W-1:0];

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Directed bench for cpu_regfile_sb: a default-sized instance (8 regs, 2 loads)
// plus a 6-register / 3-load instance for out-of-range indices and pointer wrap.
module tb_cpu_regfile_sb;

    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    cpu_regfile_sb_if #(.DATA_W(16), .IDX_W(3), .LED_W(8)) bus ();
    cpu_regfile_sb_if #(.DATA_W(16), .IDX_W(3), .LED_W(8)) bus2 ();

    cpu_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .IDX_W(3), .MAX_LOADS(2), .LED_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_regfile_sb #(.DATA_W(16), .NUM_REGS(6), .IDX_W(3), .MAX_LOADS(3), .LED_W(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic idle();
        bus.rd_l_idx  = '0; bus.rd_r_idx  = '0; bus.wr_en   = 1'b0; bus.wr_idx  = '0;
        bus.wr_data   = '0; bus.ld_issue  = 1'b0; bus.ld_idx = '0; bus.ld_done  = 1'b0;
        bus.ld_data   = '0;
        bus2.rd_l_idx = '0; bus2.rd_r_idx = '0; bus2.wr_en  = 1'b0; bus2.wr_idx = '0;
        bus2.wr_data  = '0; bus2.ld_issue = 1'b0; bus2.ld_idx = '0; bus2.ld_done = 1'b0;
        bus2.ld_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_data = 16'h1234;
        tick();
        bus.wr_idx = 3'd0; bus.wr_data = 16'hA5C3;
        tick();
        idle();
        bus.rd_l_idx = 3'd3;
        #1;
        n_compared++; if (bus.reg_leds !== 8'hC3) begin n_mismatched++; $display("[TB] FAIL leds_r0: got %h expected %h", bus.reg_leds, 8'hC3); end
        n_compared++; if (bus.rd_l_data !== 16'h1234) begin n_mismatched++; $display("[TB] FAIL pre_reset_r3: got %h expected %h", bus.rd_l_data, 16'h1234); end
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_data = 16'h5555;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h1234) begin n_mismatched++; $display("[TB] FAIL reset_no_bypass: got %h expected %h", bus.rd_l_data, 16'h1234); end
        tick();
        rst = 1'b0;
        idle();
        bus.rd_l_idx = 3'd3;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_r3: got %h expected %h", bus.rd_l_data, 16'h0000); end
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected %b", bus.ld_busy, 1'b0); end
        n_compared++; if (bus.ld_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full: got %b expected %b", bus.ld_full, 1'b0); end
        n_compared++; if (bus.hazard !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hazard: got %b expected %b", bus.hazard, 1'b0); end
        n_compared++; if (bus.reg_leds !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_leds: got %h expected %h", bus.reg_leds, 8'h00); end
    endtask

    task automatic test_write_bypass();
        idle();
        bus.wr_en = 1'b1; bus.wr_idx = 3'd2; bus.wr_data = 16'hBEEF;
        bus.rd_l_idx = 3'd2; bus.rd_r_idx = 3'd3;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'hBEEF) begin n_mismatched++; $display("[TB] FAIL bypass_l: got %h expected %h", bus.rd_l_data, 16'hBEEF); end
        n_compared++; if (bus.rd_r_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL bypass_other_idx: got %h expected %h", bus.rd_r_data, 16'h0000); end
        tick();
        bus.wr_en = 1'b0;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'hBEEF) begin n_mismatched++; $display("[TB] FAIL stored_r2: got %h expected %h", bus.rd_l_data, 16'hBEEF); end
        bus.wr_en = 1'b1; bus.wr_idx = 3'd7; bus.wr_data = 16'h0707; bus.rd_r_idx = 3'd7;
        #1;
        n_compared++; if (bus.rd_r_data !== 16'h0707) begin n_mismatched++; $display("[TB] FAIL bypass_r: got %h expected %h", bus.rd_r_data, 16'h0707); end
        tick();
        idle();
    endtask

    task automatic test_load_basic();
        idle();
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd5;
        tick();
        bus.ld_issue = 1'b0;
        #1;
        n_compared++; if (bus.ld_busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL load_busy: got %b expected %b", bus.ld_busy, 1'b1); end
        n_compared++; if (bus.ld_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL load_not_full: got %b expected %b", bus.ld_full, 1'b0); end
        bus.rd_r_idx = 3'd5;
        #1;
        n_compared++; if (bus.hazard !== 1'b1) begin n_mismatched++; $display("[TB] FAIL load_hazard: got %b expected %b", bus.hazard, 1'b1); end
        bus.ld_done = 1'b1; bus.ld_data = 16'h00AA; bus.rd_l_idx = 3'd5;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h00AA) begin n_mismatched++; $display("[TB] FAIL load_bypass: got %h expected %h", bus.rd_l_data, 16'h00AA); end
        n_compared++; if (bus.hazard !== 1'b1) begin n_mismatched++; $display("[TB] FAIL load_hazard_on_pop: got %b expected %b", bus.hazard, 1'b1); end
        tick();
        idle();
        bus.rd_r_idx = 3'd5;
        #1;
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL load_idle: got %b expected %b", bus.ld_busy, 1'b0); end
        n_compared++; if (bus.hazard !== 1'b0) begin n_mismatched++; $display("[TB] FAIL load_hazard_clear: got %b expected %b", bus.hazard, 1'b0); end
        n_compared++; if (bus.rd_r_data !== 16'h00AA) begin n_mismatched++; $display("[TB] FAIL load_r5: got %h expected %h", bus.rd_r_data, 16'h00AA); end
    endtask

    task automatic test_full();
        idle();
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd1;
        tick();
        bus.ld_idx = 3'd2;
        tick();
        bus.ld_idx = 3'd3;
        #1;
        n_compared++; if (bus.ld_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_set: got %b expected %b", bus.ld_full, 1'b1); end
        tick();
        bus.ld_issue = 1'b0; bus.rd_l_idx = 3'd3;
        #1;
        n_compared++; if (bus.hazard !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_drop_r3: got %b expected %b", bus.hazard, 1'b0); end
        n_compared++; if (bus.ld_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_hold: got %b expected %b", bus.ld_full, 1'b1); end
        bus.rd_l_idx = 3'd2;
        #1;
        n_compared++; if (bus.hazard !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_hazard_r2: got %b expected %b", bus.hazard, 1'b1); end
        bus.ld_done = 1'b1; bus.ld_data = 16'h0011;
        tick();
        bus.ld_data = 16'h0022;
        #1;
        n_compared++; if (bus.ld_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_after_pop: got %b expected %b", bus.ld_full, 1'b0); end
        n_compared++; if (bus.ld_busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_after_pop: got %b expected %b", bus.ld_busy, 1'b1); end
        tick();
        idle();
        bus.rd_l_idx = 3'd1; bus.rd_r_idx = 3'd2;
        #1;
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_drained: got %b expected %b", bus.ld_busy, 1'b0); end
        n_compared++; if (bus.rd_l_data !== 16'h0011) begin n_mismatched++; $display("[TB] FAIL full_r1: got %h expected %h", bus.rd_l_data, 16'h0011); end
        n_compared++; if (bus.rd_r_data !== 16'h0022) begin n_mismatched++; $display("[TB] FAIL full_r2: got %h expected %h", bus.rd_r_data, 16'h0022); end
        bus.rd_l_idx = 3'd3;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL full_r3: got %h expected %h", bus.rd_l_data, 16'h0000); end
    endtask

    task automatic test_collision();
        idle();
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd4;
        tick();
        bus.ld_issue = 1'b0;
        bus.wr_en = 1'b1; bus.wr_idx = 3'd4; bus.wr_data = 16'h1111;
        bus.ld_done = 1'b1; bus.ld_data = 16'h2222; bus.rd_l_idx = 3'd4;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h2222) begin n_mismatched++; $display("[TB] FAIL collide_bypass: got %h expected %h", bus.rd_l_data, 16'h2222); end
        tick();
        idle();
        bus.rd_l_idx = 3'd4;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h2222) begin n_mismatched++; $display("[TB] FAIL collide_r4: got %h expected %h", bus.rd_l_data, 16'h2222); end
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd6;
        tick();
        bus.ld_issue = 1'b0;
        bus.wr_en = 1'b1; bus.wr_idx = 3'd7; bus.wr_data = 16'h7777;
        bus.ld_done = 1'b1; bus.ld_data = 16'h6666;
        tick();
        idle();
        bus.rd_l_idx = 3'd6; bus.rd_r_idx = 3'd7;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h6666) begin n_mismatched++; $display("[TB] FAIL dual_r6: got %h expected %h", bus.rd_l_data, 16'h6666); end
        n_compared++; if (bus.rd_r_data !== 16'h7777) begin n_mismatched++; $display("[TB] FAIL dual_r7: got %h expected %h", bus.rd_r_data, 16'h7777); end
    endtask

    task automatic test_back_to_back();
        idle();
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd1;
        tick();
        bus.ld_idx = 3'd2;
        tick();
        bus.ld_idx = 3'd6; bus.ld_done = 1'b1; bus.ld_data = 16'h0077;
        tick();
        idle();
        bus.rd_l_idx = 3'd1;
        #1;
        n_compared++; if (bus.ld_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_full: got %b expected %b", bus.ld_full, 1'b1); end
        n_compared++; if (bus.rd_l_data !== 16'h0077) begin n_mismatched++; $display("[TB] FAIL b2b_r1: got %h expected %h", bus.rd_l_data, 16'h0077); end
        n_compared++; if (bus.hazard !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_r1_released: got %b expected %b", bus.hazard, 1'b0); end
        bus.rd_l_idx = 3'd6;
        #1;
        n_compared++; if (bus.hazard !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_r6_pending: got %b expected %b", bus.hazard, 1'b1); end
        bus.rd_l_idx = 3'd0; bus.wr_en = 1'b1; bus.wr_idx = 3'd2;
        #1;
        n_compared++; if (bus.hazard !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_wr_hazard: got %b expected %b", bus.hazard, 1'b1); end
        bus.wr_en = 1'b0;
        #1;
        n_compared++; if (bus.hazard !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_wr_gated: got %b expected %b", bus.hazard, 1'b0); end
        bus.ld_done = 1'b1; bus.ld_data = 16'h0088;
        tick();
        bus.ld_data = 16'h0099;
        tick();
        idle();
        bus.rd_l_idx = 3'd2; bus.rd_r_idx = 3'd6;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h0088) begin n_mismatched++; $display("[TB] FAIL b2b_r2: got %h expected %h", bus.rd_l_data, 16'h0088); end
        n_compared++; if (bus.rd_r_data !== 16'h0099) begin n_mismatched++; $display("[TB] FAIL b2b_r6: got %h expected %h", bus.rd_r_data, 16'h0099); end
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_drained: got %b expected %b", bus.ld_busy, 1'b0); end
    endtask

    task automatic test_reset_midload();
        idle();
        bus.ld_issue = 1'b1; bus.ld_idx = 3'd5;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midload_busy: got %b expected %b", bus.ld_busy, 1'b0); end
        bus.ld_done = 1'b1; bus.ld_data = 16'hDEAD; bus.rd_l_idx = 3'd5;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL late_done_bypass: got %h expected %h", bus.rd_l_data, 16'h0000); end
        tick();
        idle();
        bus.rd_l_idx = 3'd5;
        #1;
        n_compared++; if (bus.rd_l_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL late_done_r5: got %h expected %h", bus.rd_l_data, 16'h0000); end
        n_compared++; if (bus.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL late_done_busy: got %b expected %b", bus.ld_busy, 1'b0); end
    endtask

    task automatic test_nonpow2();
        idle();
        bus2.wr_en = 1'b1; bus2.wr_idx = 3'd6; bus2.wr_data = 16'hFFFF;
        bus2.rd_l_idx = 3'd6; bus2.rd_r_idx = 3'd7;
        #1;
        n_compared++; if (bus2.rd_l_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL oor_read6: got %h expected %h", bus2.rd_l_data, 16'h0000); end
        n_compared++; if (bus2.rd_r_data !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL oor_read7: got %h expected %h", bus2.rd_r_data, 16'h0000); end
        tick();
        idle();
        bus2.ld_issue = 1'b1; bus2.ld_idx = 3'd7;
        tick();
        idle();
        #1;
        n_compared++; if (bus2.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL oor_issue: got %b expected %b", bus2.ld_busy, 1'b0); end
        n_compared++; if (bus2.reg_leds !== 8'h00) begin n_mismatched++; $display("[TB] FAIL oor_leds: got %h expected %h", bus2.reg_leds, 8'h00); end
        bus2.ld_issue = 1'b1; bus2.ld_idx = 3'd1;
        tick();
        bus2.ld_idx = 3'd2;
        tick();
        bus2.ld_idx = 3'd3;
        tick();
        bus2.ld_idx = 3'd4; bus2.ld_done = 1'b1; bus2.ld_data = 16'h0101;
        #1;
        n_compared++; if (bus2.ld_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_full: got %b expected %b", bus2.ld_full, 1'b1); end
        tick();
        bus2.ld_issue = 1'b0; bus2.ld_data = 16'h0202;
        #1;
        n_compared++; if (bus2.ld_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wrap_full_hold: got %b expected %b", bus2.ld_full, 1'b1); end
        tick();
        bus2.ld_data = 16'h0303;
        tick();
        bus2.ld_data = 16'h0404;
        tick();
        idle();
        bus2.rd_l_idx = 3'd1; bus2.rd_r_idx = 3'd4;
        #1;
        n_compared++; if (bus2.ld_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_drained: got %b expected %b", bus2.ld_busy, 1'b0); end
        n_compared++; if (bus2.rd_l_data !== 16'h0101) begin n_mismatched++; $display("[TB] FAIL wrap_r1: got %h expected %h", bus2.rd_l_data, 16'h0101); end
        n_compared++; if (bus2.rd_r_data !== 16'h0404) begin n_mismatched++; $display("[TB] FAIL wrap_r4: got %h expected %h", bus2.rd_r_data, 16'h0404); end
        bus2.rd_l_idx = 3'd2; bus2.rd_r_idx = 3'd3;
        #1;
        n_compared++; if (bus2.rd_l_data !== 16'h0202) begin n_mismatched++; $display("[TB] FAIL wrap_r2: got %h expected %h", bus2.rd_l_data, 16'h0202); end
        n_compared++; if (bus2.rd_r_data !== 16'h0303) begin n_mismatched++; $display("[TB] FAIL wrap_r3: got %h expected %h", bus2.rd_r_data, 16'h0303); end
    endtask

    // Reset both instances, then run each scenario in order.
    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] starting directed tests");
        test_reset();
        test_write_bypass();
        test_load_basic();
        test_full();
        test_collision();
        test_back_to_back();
        test_reset_midload();
        test_nonpow2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
